// File: rtl/auv_csr_pkg.sv
// Shared types and constants for the CSR bus master and its address decoder.
package auv_csr_pkg;

  localparam int unsigned CSR_ADDR_W = 12;
  localparam int unsigned NSLV       = 4;

  typedef enum logic [1:0] {
    CsrOpNone = 2'b00,
    CsrOpRw   = 2'b01,
    CsrOpRs   = 2'b10,
    CsrOpRc   = 2'b11
  } csr_op_e;

  // Slave indices on the CSR bus
  localparam int unsigned SLV_MINFO = 0;
  localparam int unsigned SLV_TRAP  = 1;
  localparam int unsigned SLV_MCNT  = 2;
  localparam int unsigned SLV_UCNT  = 3;

  // Inclusive address windows per slave
  localparam logic [CSR_ADDR_W-1:0] MINFO_BASE  = 12'hF11;
  localparam logic [CSR_ADDR_W-1:0] MINFO_LIMIT = 12'hF15;
  localparam logic [CSR_ADDR_W-1:0] TRAP_BASE   = 12'h300;
  localparam logic [CSR_ADDR_W-1:0] TRAP_LIMIT  = 12'h3FF;
  localparam logic [CSR_ADDR_W-1:0] MCNT_BASE   = 12'hB00;
  localparam logic [CSR_ADDR_W-1:0] MCNT_LIMIT  = 12'hBFF;
  localparam logic [CSR_ADDR_W-1:0] UCNT_BASE   = 12'hC00;
  localparam logic [CSR_ADDR_W-1:0] UCNT_LIMIT  = 12'hCFF;

  // Zicsr encodes read-only CSRs with the top two address bits set
  function automatic logic csr_is_ro(logic [CSR_ADDR_W-1:0] addr);
    return addr[11:10] == 2'b11;
  endfunction

endpackage

// File: rtl/auv_csr_decode.sv
// CSR address decoder: one-hot slave select plus illegal-access flag.
module auv_csr_decode
  import auv_csr_pkg::*;
(
  input  logic [CSR_ADDR_W-1:0] addr,
  input  logic                  wr_en,
  output logic [NSLV-1:0]       sel,
  output logic                  illegal
);

  // Match the address against each slave window; unmapped or write-to-RO is illegal
  always_comb begin
    sel = '0;
    if (addr >= MINFO_BASE && addr <= MINFO_LIMIT) sel[SLV_MINFO] = 1'b1;
    if (addr >= TRAP_BASE  && addr <= TRAP_LIMIT)  sel[SLV_TRAP]  = 1'b1;
    if (addr >= MCNT_BASE  && addr <= MCNT_LIMIT)  sel[SLV_MCNT]  = 1'b1;
    if (addr >= UCNT_BASE  && addr <= UCNT_LIMIT)  sel[SLV_UCNT]  = 1'b1;
    illegal = (sel == '0) || (wr_en && csr_is_ro(addr));
  end

endmodule

// File: rtl/auv_csr_ctrl.sv
// CSR bus master: runs one Zicsr op as optional read then optional write phase.
module auv_csr_ctrl
  import auv_csr_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_op,
  input  logic [CSR_ADDR_W-1:0]  req_addr,
  input  logic [31:0]            req_wdata,
  input  logic                   req_rd_en,
  input  logic                   req_wr_en,
  output logic                   rsp_valid,
  output logic [31:0]            rsp_rdata,
  output logic                   rsp_illegal,
  output logic [NSLV-1:0]        cbus_sel,
  output logic [CSR_ADDR_W-1:0]  cbus_addr,
  output logic [31:0]            cbus_dat_wr,
  output logic                   cbus_rd,
  output logic                   cbus_wr,
  input  logic [NSLV*32-1:0]     cbus_dat_rd,
  input  logic [NSLV-1:0]        cbus_ack
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e                state_q, state_d;
  csr_op_e               op_q, op_d;
  logic [CSR_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_en_q, wr_en_d;
  logic [NSLV-1:0]       sel_q, sel_d;
  logic [31:0]           old_q, old_d;
  logic [31:0]           new_q, new_d;
  logic                  illegal_q, illegal_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [NSLV-1:0] dec_sel;
  logic            dec_illegal;
  logic [31:0]     rd_word;
  logic [31:0]     rmw_val;
  logic            ack_ok;
  logic            timeout_hit;

  auv_csr_decode u_decode (
    .addr    (req_addr),
    .wr_en   (req_wr_en),
    .sel     (dec_sel),
    .illegal (dec_illegal)
  );

  // Select read data of the latched slave
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < int'(NSLV); i++) begin
      if (sel_q[i]) rd_word = rd_word | cbus_dat_rd[i*32 +: 32];
    end
  end

  // Read-modify-write value from freshly read data
  always_comb begin
    unique case (op_q)
      CsrOpRs: rmw_val = rd_word | wdata_q;
      CsrOpRc: rmw_val = rd_word & ~wdata_q;
      default: rmw_val = wdata_q;
    endcase
  end

  // First phase cycle may carry a stale ack held from the previous phase
  assign ack_ok      = (cnt_q != 8'd0) && |(cbus_ack & sel_q);
  assign timeout_hit = cnt_q == 8'(TIMEOUT - 1);

  // Next-state, capture and timeout logic
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wr_en_d   = wr_en_q;
    sel_d     = sel_q;
    old_d     = old_q;
    new_d     = new_q;
    illegal_d = illegal_q;
    cnt_d     = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_op != CsrOpNone) begin
          op_d      = csr_op_e'(req_op);
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wr_en_d   = req_wr_en;
          sel_d     = dec_sel;
          old_d     = '0;
          new_d     = req_wdata;
          illegal_d = dec_illegal;
          if (dec_illegal) begin
            state_d = StResp;
          end else if (req_rd_en || csr_op_e'(req_op) != CsrOpRw) begin
            state_d = StRead;
          end else begin
            state_d = StWrite;
          end
        end
      end
      StRead: begin
        if (ack_ok) begin
          old_d   = rd_word;
          new_d   = rmw_val;
          state_d = wr_en_q ? StWrite : StResp;
        end else if (timeout_hit) begin
          illegal_d = 1'b1;
          old_d     = '0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: begin
        if (ack_ok) begin
          state_d = StResp;
        end else if (timeout_hit) begin
          illegal_d = 1'b1;
          old_d     = '0;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      op_q      <= CsrOpNone;
      addr_q    <= '0;
      wdata_q   <= '0;
      wr_en_q   <= 1'b0;
      sel_q     <= '0;
      old_q     <= '0;
      new_q     <= '0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wr_en_q   <= wr_en_d;
      sel_q     <= sel_d;
      old_q     <= old_d;
      new_q     <= new_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    req_ready   = state_q == StIdle;
    rsp_valid   = state_q == StResp;
    rsp_rdata   = rsp_valid ? old_q : '0;
    rsp_illegal = rsp_valid && illegal_q;
    cbus_rd     = state_q == StRead;
    cbus_wr     = state_q == StWrite;
    cbus_sel    = (cbus_rd || cbus_wr) ? sel_q : '0;
    cbus_addr   = addr_q;
    cbus_dat_wr = new_q;
  end

endmodule

// File: tb/tb_auv_csr_ctrl.sv
// Scoreboard bench for auv_csr_ctrl with behavioural CSR slaves.
module tb_auv_csr_ctrl;

  localparam int unsigned TO = 15;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid;
  logic         req_ready;
  logic [1:0]   req_op;
  logic [11:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         req_rd_en;
  logic         req_wr_en;
  logic         rsp_valid;
  logic [31:0]  rsp_rdata;
  logic         rsp_illegal;
  logic [3:0]   cbus_sel;
  logic [11:0]  cbus_addr;
  logic [31:0]  cbus_dat_wr;
  logic         cbus_rd;
  logic         cbus_wr;
  logic [127:0] cbus_dat_rd;
  logic [3:0]   cbus_ack;

  logic [31:0]  slv_val [4];
  logic [3:0]   ack_en;
  logic [3:0]   ack_force;

  always #5 clk = ~clk;

  auv_csr_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_rd_en   (req_rd_en),
    .req_wr_en   (req_wr_en),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_illegal (rsp_illegal),
    .cbus_sel    (cbus_sel),
    .cbus_addr   (cbus_addr),
    .cbus_dat_wr (cbus_dat_wr),
    .cbus_rd     (cbus_rd),
    .cbus_wr     (cbus_wr),
    .cbus_dat_rd (cbus_dat_rd),
    .cbus_ack    (cbus_ack)
  );

  // Zero-wait slaves that hold ack for as long as they are selected
  for (genvar g = 0; g < 4; g++) begin : g_slv
    assign cbus_ack[g] = (cbus_sel[g] & ack_en[g]) | ack_force[g];
    assign cbus_dat_rd[g*32 +: 32] = slv_val[g];
  end

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
    int          lat;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  sel;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   n_sent = 0;
  int   n_rsp = 0;
  int   lat = 1000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int slave_of(input logic [11:0] a);
    if (a >= 12'hF11 && a <= 12'hF15) return 0;
    if (a >= 12'h300 && a <= 12'h3FF) return 1;
    if (a >= 12'hB00 && a <= 12'hBFF) return 2;
    if (a >= 12'hC00 && a <= 12'hCFF) return 3;
    return -1;
  endfunction

  // Drive one request, push its expected response unless it will be lost to reset
  task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input logic rd, input logic wr, input bit exp_to, input bit no_rsp);
    exp_t        e;
    int          idx;
    int          n;
    logic        rdph;
    logic [31:0] old;
    logic [31:0] nv;
    idx  = slave_of(addr);
    old  = (idx >= 0) ? slv_val[idx] : 32'h0;
    rdph = rd || (op != 2'b01);
    case (op)
      2'b01:   nv = wd;
      2'b10:   nv = old | wd;
      default: nv = old & ~wd;
    endcase
    e.illegal = (idx < 0) || (wr && addr[11:10] == 2'b11);
    e.sel     = '0;
    e.rdata   = '0;
    e.rd      = 1'b0;
    e.wr      = 1'b0;
    e.wdata   = '0;
    e.lat     = 1;
    if (!e.illegal) begin
      e.sel = 4'b0001 << idx;
      if (exp_to) begin
        e.illegal = 1'b1;
        e.rd      = 1'b1;
        e.lat     = TO + 1;
      end else begin
        e.rdata = rdph ? old : 32'h0;
        e.rd    = rdph;
        e.wr    = wr;
        e.wdata = nv;
        e.lat   = (rdph && wr) ? 5 : 3;
      end
    end
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_rd_en = rd;
    req_wr_en = wr;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) chk("req_ready_wait", {31'h0, req_ready}, 32'h1);
    if (!no_rsp) begin
      sb.push_back(e);
      n_sent++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op    = 2'b00;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_wait_expired", sb.size(), 32'h0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  // Cycle count since the accept edge (1 = first cycle after accept)
  initial begin
    forever begin
      @(posedge clk);
      lat = (req_valid && req_ready && req_op != 2'b00) ? 1 : lat + 1;
    end
  end

  // Monitor: accumulate bus activity per transaction, compare at the response
  initial begin
    logic        seen_rd;
    logic        seen_wr;
    logic [3:0]  seen_sel;
    logic [31:0] seen_wd;
    exp_t        e;
    seen_rd = 0; seen_wr = 0; seen_sel = '0; seen_wd = '0;
    forever begin
      @(negedge clk);
      if (lat == 1) begin
        seen_rd = 0; seen_wr = 0; seen_sel = '0; seen_wd = '0;
      end
      if (cbus_rd) seen_rd = 1'b1;
      if (cbus_wr) begin
        seen_wr = 1'b1;
        seen_wd = cbus_dat_wr;
      end
      seen_sel = seen_sel | cbus_sel;
      if (rsp_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 32'h1, 32'h0);
        end else begin
          e = sb.pop_front();
          n_rsp++;
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_illegal", {31'h0, rsp_illegal}, {31'h0, e.illegal});
          chk("rsp_latency", lat, e.lat);
          chk("read_phase", {31'h0, seen_rd}, {31'h0, e.rd});
          chk("write_phase", {31'h0, seen_wr}, {31'h0, e.wr});
          if (e.wr) chk("write_data", seen_wd, e.wdata);
          chk("slave_sel", {28'h0, seen_sel}, {28'h0, e.sel});
          chk("strobes_idle_in_rsp", {26'h0, cbus_rd, cbus_wr, cbus_sel}, 32'h0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  logic [11:0] addr_tbl [8];

  initial begin
    logic [1:0]  op;
    logic [31:0] wd;
    logic        rd;
    req_valid = 0; req_op = 0; req_addr = 0; req_wdata = 0; req_rd_en = 0; req_wr_en = 0;
    for (int i = 0; i < 4; i++) slv_val[i] = 32'h0;
    ack_en = 4'hF;
    ack_force = 4'h0;
    addr_tbl[0] = 12'hF11; addr_tbl[1] = 12'hF14; addr_tbl[2] = 12'h300; addr_tbl[3] = 12'h341;
    addr_tbl[4] = 12'hB02; addr_tbl[5] = 12'hC01; addr_tbl[6] = 12'h7C0; addr_tbl[7] = 12'hBFF;

    // Reset values
    #12;
    chk("rst_req_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_rsp_illegal", {31'h0, rsp_illegal}, 32'h0);
    chk("rst_strobes", {26'h0, cbus_rd, cbus_wr, cbus_sel}, 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_cbus_addr", {20'h0, cbus_addr}, 32'h0);
    chk("rst_cbus_dat_wr", cbus_dat_wr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    slv_val[0] = 32'h0;
    send(2'b10, 12'hF11, 32'h0, 1, 0, 0, 0); wait_idle();
    slv_val[1] = 32'h8;
    send(2'b10, 12'h300, 32'h80, 1, 1, 0, 0); wait_idle();
    slv_val[1] = 32'hFF;
    send(2'b11, 12'h300, 32'h0F, 1, 1, 0, 0); wait_idle();
    slv_val[2] = 32'h5555;
    send(2'b01, 12'hB00, 32'h1234, 0, 1, 0, 0); wait_idle();
    send(2'b01, 12'hF11, 32'h5, 1, 1, 0, 0); wait_idle();
    send(2'b10, 12'h7C0, 32'h0, 1, 0, 0, 0); wait_idle();
    send(2'b01, 12'hC05, 32'h1, 0, 1, 0, 0); wait_idle();
    slv_val[3] = 32'hCAFE_F00D;
    send(2'b10, 12'hC00, 32'h0, 1, 0, 0, 0); wait_idle();
    slv_val[0] = 32'h1357_9BDF;
    send(2'b10, 12'hF15, 32'h0, 1, 0, 0, 0); wait_idle();
    send(2'b10, 12'hF16, 32'h0, 1, 0, 0, 0); wait_idle();
    send(2'b10, 12'hF10, 32'h0, 1, 0, 0, 0); wait_idle();
    send(2'b01, 12'h3FF, 32'hDEAD_BEEF, 1, 1, 0, 0); wait_idle();
    send(2'b11, 12'hBFF, 32'hF0F0_0000, 1, 1, 0, 0); wait_idle();
    send(2'b10, 12'h2FF, 32'h0, 1, 0, 0, 0); wait_idle();
    send(2'b10, 12'hD00, 32'h0, 1, 0, 0, 0); wait_idle();

    // Back-to-back with held acks; request held high while busy
    slv_val[1] = 32'h0000_0F00; slv_val[2] = 32'hA5A5_0000; slv_val[3] = 32'h77;
    send(2'b10, 12'h300, 32'h1, 1, 1, 0, 0);
    send(2'b01, 12'hB00, 32'h42, 0, 1, 0, 0);
    send(2'b10, 12'hC00, 32'h0, 1, 0, 0, 0);
    send(2'b01, 12'h7C0, 32'h9, 1, 1, 0, 0);
    send(2'b11, 12'hB10, 32'hFFFF_0000, 0, 1, 0, 0);
    wait_idle();

    // Timeout on slave 1 while unselected slaves ack
    ack_en = 4'b1101;
    ack_force = 4'b1101;
    send(2'b10, 12'h300, 32'h80, 1, 1, 1, 0); wait_idle();
    ack_en = 4'hF;
    ack_force = 4'h0;
    slv_val[1] = 32'h10;
    send(2'b10, 12'h300, 32'h01, 1, 1, 0, 0); wait_idle();

    // op 00 is never accepted
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 12'h300; req_rd_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("op00_ignored_ready", {31'h0, req_ready}, 32'h1);
    end
    req_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Randomised traffic
    for (int k = 0; k < 12; k++) begin
      for (int s = 0; s < 4; s++) slv_val[s] = $urandom;
      op = 2'($urandom_range(1, 3));
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      rd = 1'($urandom_range(0, 1));
      send(op, addr_tbl[$urandom_range(0, 7)], wd, rd, (op == 2'b01) || (wd != 0), 0, 0);
      wait_idle();
    end

    // Reset during the write phase drops everything, no response
    send(2'b01, 12'hB00, 32'hBAD, 0, 1, 0, 1);
    chk("write_before_rst", {31'h0, cbus_wr}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr", {31'h0, cbus_wr}, 32'h0);
    chk("rst_mid_sel", {28'h0, cbus_sel}, 32'h0);
    chk("rst_mid_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    slv_val[2] = 32'h600D;
    send(2'b10, 12'hB00, 32'h0, 1, 0, 0, 0); wait_idle();

    chk("scoreboard_empty", sb.size(), 32'h0);
    chk("rsp_count", n_rsp, n_sent);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/auv_csr_ctrl.md
# auv_csr_ctrl

CSR bus master sitting between the execute stage and the CSR slaves (machine-info stub, trap CSRs, counters). It accepts one Zicsr operation at a time from execute, decodes the CSR address to a one-hot slave select, and runs a read and/or write phase on the CSR bus using the sel/rd/wr/ack protocol. It then returns the old CSR value, or an illegal-instruction flag, to the pipeline.

## Interface
- TIMEOUT, 15: cycles a bus phase may wait for ack before aborting as illegal; range 2..255
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- req_valid  in  1  execute presents a CSR op
- req_ready  out  1  block idle, request accepted this cycle if req_valid
- req_op  in  2  csr_op_e: RW=01, RS=10, RC=11; 00 is ignored (no accept)
- req_addr  in  12  CSR address
- req_wdata  in  32  rs1 value or zero-extended uimm
- req_rd_en  in  1  rd != x0
- req_wr_en  in  1  write intended (RW always 1; RS/RC: rs1/uimm != 0)
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  32  old CSR value (0 if no read phase or illegal)
- rsp_illegal  out  1  raise illegal-instruction trap; valid with rsp_valid
- cbus_sel  out  4  one-hot slave select
- cbus_addr  out  12  latched CSR address
- cbus_dat_wr  out  32  value to write
- cbus_rd, cbus_wr  out  1  phase strobes
- cbus_dat_rd  in  4x32  per-slave read data, slave 0 in bits [31:0]
- cbus_ack  in  4  per-slave ack

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid with op≠00, latch op/addr/wdata/rd_en/wr_en and decode the address.
  - Illegal → RESP. Illegal means no slave match, or wr_en with addr[11:10]==2'b11.
  - Else read needed (rd_en, or op RS/RC) → READ.
  - Else → WRITE.
- Address map (slave idx): 0 = 0xF11–0xF15 machine info; 1 = 0x300–0x3FF trap setup/handling; 2 = 0xB00–0xBFF machine counters; 3 = 0xC00–0xCFF user counters.
- READ: drive sel[idx]=1, rd=1, wr=0. On a valid ack[idx]:
  - capture cbus_dat_rd[idx] as old;
  - compute new = RW: wdata; RS: old|wdata; RC: old&~wdata;
  - go to WRITE if wr_en, else RESP.
- WRITE: drive sel[idx]=1, wr=1, rd=0, cbus_dat_wr=new (RW without read phase: wdata). Valid ack → RESP.
- RESP: rsp_valid=1, rsp_rdata=old (0 if no read), rsp_illegal per above. Next state is IDLE unconditionally; execute must accept the response.
- Ack qualification: ack is ignored in the first cycle of every phase. Slaves hold ack while sel stays high, so the first-cycle ack may be stale from the previous phase.
- Timeout: per-phase 8-bit counter cleared on phase entry. When it reaches TIMEOUT with no valid ack → RESP with illegal=1, rdata=0, and no write phase.
- Acks from unselected slaves are ignored.

## Timing
- Reset: state IDLE; rsp_valid, rsp_illegal, cbus_sel, cbus_rd, cbus_wr = 0; rsp_rdata, cbus_addr, cbus_dat_wr = 0; req_ready=1 (combinational from IDLE).
- All strobes are decoded from registered state; no combinational path from cbus_ack to cbus_* outputs.
- Each phase lasts at least 2 cycles. Latency is measured from the accept edge (cycle 0) with a zero-wait slave:
  - read-only: READ cycles 1–2, rsp_valid cycle 3;
  - read+write: READ 1–2, WRITE 3–4, rsp cycle 5;
  - write-only: rsp cycle 3;
  - decode-illegal: rsp cycle 1.
- Strobes drop in RESP, guaranteeing one idle bus cycle between transactions.
- Asynchronous reset mid-operation: strobes drop immediately, the transaction is lost, and no response is produced.
- req_valid during non-IDLE states is ignored (req_ready=0).

## Structure
- auv_csr_pkg holds:
  - csr_op_e;
  - CSR_ADDR_W=12 and NSLV=4;
  - slave index constants;
  - address range base/limit constants;
  - the read-only-address helper function.
- Sub-module auv_csr_decode: combinational addr + wr_en → one-hot sel[3:0] and illegal.
- The FSM, timeout counter, data capture and RMW logic live in auv_csr_ctrl.

## Test plan
- CSRRS x5, 0xF11, rs1=x0 with slave 0 returning 0 → single READ phase, no cbus_wr ever, rsp_rdata=0 at cycle 3, illegal=0.
- CSRRS 0x300 old=0x0000_0008, wdata=0x80 → WRITE drives 0x0000_0088; rsp_rdata=0x8 at cycle 5.
- CSRRC 0x300 old=0xFF, wdata=0x0F → write 0xF0. CSRRW rd=x0 to 0xB00 → no cbus_rd pulse; rsp at cycle 3.
- CSRRW to 0xF11, and any op to unmapped 0x7C0 → rsp_illegal=1 at cycle 1, cbus_sel never asserted.
- Slave 1 never acks, TIMEOUT=15 → rsp_illegal=1 and strobes drop after 15 READ cycles; the next request then completes normally.
- Back-to-back requests with slaves holding ack → no stale-ack early completion; rst_n pulsed during WRITE → outputs 0 immediately, no rsp_valid.
